// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
package mem_stage_pkg;

    localparam int unsigned BEATS_PER_WORD = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        K_PASS  = 2'd0,
        K_LOAD  = 2'd1,
        K_STORE = 2'd2
    } kind_e;

    // Store wins over load so a mem_write entry never writes the register file.
    function automatic kind_e decode_kind(
        input logic bubble,
        input logic mem_write,
        input logic write_enable,
        input logic alu_wb
    );
        kind_e k;
        k = K_PASS;
        if (!bubble) begin
            if (mem_write) begin
                k = K_STORE;
            end else if (write_enable && !alu_wb) begin
                k = K_LOAD;
            end
        end
        return k;
    endfunction

endpackage

// File: rtl/mem_byte_serializer.sv
// Byte-serial beat sequencer: address/byte select, load assembly and per-beat ack timeout.
module mem_byte_serializer
    import mem_stage_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            start_i,
    input  logic            active_i,
    input  logic            ack_i,
    input  logic [XLEN-1:0] base_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [7:0]      rdata_i,
    output logic [XLEN-1:0] addr_o,
    output logic [7:0]      wbyte_o,
    output logic [XLEN-1:0] word_o,
    output logic            done_o,
    output logic            timeout_o
);

    localparam int unsigned WAIT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(ACK_TIMEOUT);
    localparam logic [1:0] LAST_BEAT = 2'(BEATS_PER_WORD - 1);

    logic [1:0]        beat_q, beat_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [XLEN-1:0]   word_q, word_d;

    // Address arithmetic wraps naturally at the top of the address space.
    assign addr_o    = base_i + XLEN'(beat_q);
    assign wbyte_o   = wdata_i[{beat_q, 3'b000} +: 8];
    assign word_o    = word_q;
    assign timeout_o = active_i && (ACK_TIMEOUT != 0) && (wait_q == WAIT_MAX);
    assign done_o    = ack_i && (beat_q == LAST_BEAT);

    always_comb begin
        beat_d = beat_q;
        wait_d = wait_q;
        word_d = word_q;
        if (start_i) begin
            beat_d = '0;
            wait_d = '0;
            word_d = '0;
        end else if (active_i) begin
            if (ack_i) begin
                word_d[{beat_q, 3'b000} +: 8] = rdata_i;
                beat_d = beat_q + 2'd1;
                wait_d = '0;
            end else if (!timeout_o) begin
                wait_d = wait_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            beat_q <= '0;
            wait_q <= '0;
        end else begin
            beat_q <= beat_d;
            wait_q <= wait_d;
        end
    end

    always_ff @(posedge clk) begin
        word_q <= word_d;
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// RISC memory stage: decodes EX/MEM entries, runs word loads/stores over a byte-serial bus,
// stalls upstream during transfers and registers the MEM/WB result.
module mem_stage_lsu
    import mem_stage_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            ex_branch,
    input  logic            ex_alu_wb,
    input  logic            ex_mem_write,
    input  logic            ex_write_enable,
    input  logic            ex_jump,
    input  logic            ex_bubble,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_alu,
    input  logic [XLEN-1:0] ex_write_data,
    input  logic [4:0]      ex_rd,
    output logic            stall,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [7:0]      mem_wdata,
    input  logic [7:0]      mem_rdata,
    input  logic            mem_ack,
    output logic            wb_valid,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_branch,
    output logic            mem_err
);

    state_e          state_q;
    kind_e           kind_q;
    kind_e           ex_kind;
    logic [XLEN-1:0] base_q;
    logic [XLEN-1:0] sdata_q;
    logic [4:0]      rd_q;
    logic            branch_q;

    logic            wb_valid_q;
    logic            wb_we_q;
    logic [4:0]      wb_rd_q;
    logic [XLEN-1:0] wb_data_q;
    logic            wb_branch_q;
    logic            err_q;

    logic            start;
    logic            xfer;
    logic            bus_ack;
    logic            ser_done;
    logic            ser_timeout;
    logic [XLEN-1:0] ser_addr;
    logic [7:0]      ser_byte;
    logic [XLEN-1:0] ser_word;

    assign ex_kind = decode_kind(ex_bubble, ex_mem_write, ex_write_enable, ex_alu_wb);
    assign start   = (state_q == ST_IDLE) && (ex_kind != K_PASS);
    assign xfer    = (state_q == ST_XFER);

    // The request drops in the timeout cycle so a late ack cannot complete the beat.
    assign mem_req   = xfer && !ser_timeout;
    assign mem_we    = mem_req && (kind_q == K_STORE);
    assign mem_addr  = mem_req ? ser_addr : '0;
    assign mem_wdata = mem_we ? ser_byte : 8'h00;
    assign bus_ack   = mem_ack && mem_req;
    assign stall     = start || xfer;

    assign wb_valid  = wb_valid_q;
    assign wb_we     = wb_we_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign wb_branch = wb_branch_q;
    assign mem_err   = err_q;

    mem_byte_serializer #(
        .XLEN        (XLEN),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_ser (
        .clk       (clk),
        .clr       (clr),
        .start_i   (start),
        .active_i  (xfer),
        .ack_i     (bus_ack),
        .base_i    (base_q),
        .wdata_i   (sdata_q),
        .rdata_i   (mem_rdata),
        .addr_o    (ser_addr),
        .wbyte_o   (ser_byte),
        .word_o    (ser_word),
        .done_o    (ser_done),
        .timeout_o (ser_timeout)
    );

    always_ff @(posedge clk) begin
        if (start) begin
            base_q   <= ex_alu;
            sdata_q  <= ex_write_data;
            rd_q     <= ex_rd;
            branch_q <= ex_branch;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= ST_IDLE;
            kind_q      <= K_PASS;
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            wb_branch_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    err_q <= 1'b0;
                    if (ex_kind != K_PASS) begin
                        kind_q      <= ex_kind;
                        wb_valid_q  <= 1'b0;
                        wb_we_q     <= 1'b0;
                        wb_rd_q     <= '0;
                        wb_data_q   <= '0;
                        wb_branch_q <= 1'b0;
                        state_q     <= ST_XFER;
                    end else begin
                        wb_valid_q  <= !ex_bubble;
                        wb_we_q     <= ex_write_enable && !ex_bubble && (ex_rd != 5'd0);
                        wb_rd_q     <= ex_rd;
                        wb_data_q   <= ex_jump ? (ex_pc + XLEN'(4)) : ex_alu;
                        wb_branch_q <= ex_branch;
                    end
                end
                ST_XFER: begin
                    wb_valid_q <= 1'b0;
                    wb_we_q    <= 1'b0;
                    if (ser_timeout) begin
                        err_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (ser_done) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // err_q is still set here only when the transfer ended by timeout.
                    err_q       <= 1'b0;
                    wb_valid_q  <= 1'b1;
                    wb_rd_q     <= rd_q;
                    wb_we_q     <= (kind_q == K_LOAD) && (rd_q != 5'd0) && !err_q;
                    wb_data_q   <= (kind_q == K_LOAD) ? ser_word : '0;
                    wb_branch_q <= branch_q;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: vector table through a pipeline-style driver, a byte-serial memory
// responder with a bus scoreboard, a writeback scoreboard, plus timeout and mid-transfer reset sequences.
module tb_mem_stage_lsu;

    logic        clk;
    logic        clr;
    logic        ex_branch, ex_alu_wb, ex_mem_write, ex_write_enable, ex_jump, ex_bubble;
    logic [31:0] ex_pc, ex_alu, ex_write_data;
    logic [4:0]  ex_rd;
    logic        stall, mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        wb_valid, wb_we, wb_branch, mem_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    typedef struct {
        logic        bubble;
        logic        mem_write;
        logic        we;
        logic        alu_wb;
        logic        jump;
        logic        branch;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [4:0]  rd;
        int          wait_cyc;
        int          nbeats;
        logic        exp_valid;
        logic        exp_we;
        logic [31:0] exp_data;
        int          exp_stall;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        br;
    } wb_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [7:0]  data;
    } bus_t;

    wb_t  wb_q[$];
    bus_t bus_q[$];
    logic [7:0] mem [logic [31:0]];
    vec_t vecs [13];
    vec_t v_clr, v_reload, v_to;

    int n_cmp = 0;
    int n_bad = 0;
    int rsp_wait = 0;
    int wcnt = 0;
    bit blk_en = 1'b0;
    logic [31:0] blk_addr = 32'h0;

    mem_stage_lsu #(
        .XLEN        (32),
        .ACK_TIMEOUT (4)
    ) dut (
        .clk             (clk),
        .clr             (clr),
        .ex_branch       (ex_branch),
        .ex_alu_wb       (ex_alu_wb),
        .ex_mem_write    (ex_mem_write),
        .ex_write_enable (ex_write_enable),
        .ex_jump         (ex_jump),
        .ex_bubble       (ex_bubble),
        .ex_pc           (ex_pc),
        .ex_alu          (ex_alu),
        .ex_write_data   (ex_write_data),
        .ex_rd           (ex_rd),
        .stall           (stall),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_ack         (mem_ack),
        .wb_valid        (wb_valid),
        .wb_we           (wb_we),
        .wb_rd           (wb_rd),
        .wb_data         (wb_data),
        .wb_branch       (wb_branch),
        .mem_err         (mem_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event occurred that must not occur", name);
    endtask

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 8'h00;
    endfunction

    // Byte-serial memory: acks after rsp_wait idle cycles per beat, never acks blk_addr when blk_en.
    always @(negedge clk) begin : responder
        bus_t b;
        mem_ack = 1'b0;
        if (mem_req === 1'b1) begin
            if (blk_en && mem_addr == blk_addr) begin
                mem_ack = 1'b0;
            end else if (wcnt < rsp_wait) begin
                wcnt++;
            end else begin
                wcnt = 0;
                mem_ack = 1'b1;
                mem_rdata = mem_rd(mem_addr);
                if (bus_q.size() == 0) begin
                    fail("bus_unexpected_beat");
                end else begin
                    b = bus_q.pop_front();
                    check("bus_addr", mem_addr, b.addr);
                    check("bus_we", mem_we, b.we);
                    if (b.we) check("bus_wdata", mem_wdata, b.data);
                end
                if (mem_we === 1'b1) mem[mem_addr] = mem_wdata;
            end
        end else begin
            wcnt = 0;
        end
    end

    always @(negedge clk) begin : wb_monitor
        wb_t e;
        if (wb_valid === 1'b1) begin
            if (wb_q.size() == 0) begin
                fail("wb_unexpected_valid");
            end else begin
                e = wb_q.pop_front();
                check("wb_we", wb_we, e.we);
                check("wb_rd", wb_rd, e.rd);
                check("wb_data", wb_data, e.data);
                check("wb_branch", wb_branch, e.br);
            end
        end
    end

    task automatic drive_bubble();
        ex_bubble = 1'b1; ex_mem_write = 1'b0; ex_write_enable = 1'b0; ex_alu_wb = 1'b0;
        ex_jump = 1'b0; ex_branch = 1'b0; ex_pc = '0; ex_alu = '0; ex_write_data = '0; ex_rd = '0;
    endtask

    task automatic set_entry(input vec_t v);
        wb_t  w;
        bus_t b;
        ex_bubble = v.bubble; ex_mem_write = v.mem_write; ex_write_enable = v.we;
        ex_alu_wb = v.alu_wb; ex_jump = v.jump; ex_branch = v.branch;
        ex_pc = v.pc; ex_alu = v.alu; ex_write_data = v.wdata; ex_rd = v.rd;
        rsp_wait = v.wait_cyc;
        if (v.exp_valid) begin
            w.we = v.exp_we; w.rd = v.rd; w.data = v.exp_data; w.br = v.branch;
            wb_q.push_back(w);
        end
        for (int i = 0; i < v.nbeats; i++) begin
            b.addr = v.alu + i;
            b.we   = v.mem_write;
            b.data = v.wdata[8*i +: 8];
            bus_q.push_back(b);
        end
    endtask

    // Holds the entry like an upstream pipeline register until a cycle ends with stall low.
    task automatic wait_consumed(output int stalls);
        stalls = 0;
        @(negedge clk);
        while (stall === 1'b1 && stalls < 300) begin
            stalls++;
            @(negedge clk);
        end
        if (stalls >= 300) fail("consume_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int st;
        set_entry(v);
        wait_consumed(st);
        check({tag, "_stall_cycles"}, st, v.exp_stall);
        drive_bubble();
        @(negedge clk);
        #1;
        check({tag, "_wb_latency"}, wb_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int guard;
        int cnt;

        //            bub  mw   we   awb  jmp  br   pc            alu           wdata         rd  wt nb  ev   ewe  edata         est
        vecs[0]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,        32'h0000_1234,32'h0,        5'd5, 0,0,1'b1,1'b1,32'h0000_1234, 0};
        vecs[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        32'hDEAD_BEEF,32'h0,        5'd7, 0,0,1'b1,1'b0,32'hDEAD_BEEF, 0};
        vecs[2]  = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,32'h40,       32'h0000_0999,32'h0,        5'd1, 0,0,1'b1,1'b1,32'h0000_0044, 0};
        vecs[3]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,        32'h0000_0055,32'h0,        5'd0, 0,0,1'b1,1'b0,32'h0000_0055, 0};
        vecs[4]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0000_0100,32'h0000_FFFF,5'd2, 0,0,1'b0,1'b0,32'h0,         0};
        vecs[5]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,        32'h0000_0100,32'h0,        5'd3, 0,4,1'b1,1'b1,32'h1234_5678, 5};
        vecs[6]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,32'h0,        32'hFFFF_FFFE,32'hAABB_CCDD,5'd9, 2,4,1'b1,1'b0,32'h0,        13};
        vecs[7]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,        32'hFFFF_FFFE,32'h0,        5'd0, 1,4,1'b1,1'b0,32'hAABB_CCDD, 9};
        vecs[8]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,        32'hFFFF_FFFF,32'h0,        5'd31,0,4,1'b1,1'b1,32'h11AA_BBCC, 5};
        vecs[9]  = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,32'hFFFF_FFFC,32'h0000_0007,32'h0,        5'd2, 0,0,1'b1,1'b1,32'h0,         0};
        vecs[10] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0000_0300,32'h0102_0304,5'd8, 0,4,1'b1,1'b0,32'h0,         5};
        vecs[11] = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b1,32'h0,        32'h0000_0077,32'h0,        5'd3, 0,0,1'b0,1'b0,32'h0,         0};
        vecs[12] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,        32'h0000_0300,32'h0,        5'd10,3,4,1'b1,1'b1,32'h0102_0304,17};

        v_to     = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,32'h0,        32'h0000_0200,32'h1122_3344,5'd4, 0,2,1'b1,1'b0,32'h0,         0};
        v_clr    = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,        32'h0000_0100,32'h0,        5'd6, 1,1,1'b0,1'b0,32'h0,         0};
        v_reload = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,        32'h0000_0100,32'h0,        5'd6, 0,4,1'b1,1'b1,32'h1234_5678, 5};

        mem[32'h100] = 8'h78; mem[32'h101] = 8'h56; mem[32'h102] = 8'h34; mem[32'h103] = 8'h12;
        mem[32'h2]   = 8'h11; mem[32'h3]   = 8'h22;

        mem_ack = 1'b0;
        mem_rdata = 8'h00;
        drive_bubble();
        clr = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", stall, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_we", wb_we, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_wb_rd", wb_rd, 0);
        check("rst_mem_err", mem_err, 0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Timeout on beat 2 of a store.
        blk_en = 1'b1;
        blk_addr = 32'h202;
        set_entry(v_to);
        guard = 0;
        @(negedge clk);
        while (!(mem_req === 1'b1 && mem_addr == 32'h202) && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        check("to_reach_beat2", guard < 50, 1);
        cnt = 0;
        while (mem_req === 1'b1 && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        check("to_req_cycles", cnt, 4);
        check("to_err_before", mem_err, 0);
        check("to_stall_hold", stall, 1);
        @(negedge clk);
        check("to_err_pulse", mem_err, 1);
        check("to_done_stall", stall, 0);
        @(posedge clk);
        #1;
        drive_bubble();
        @(negedge clk);
        check("to_err_clear", mem_err, 0);
        check("to_idle_stall", stall, 0);
        #1;
        check("to_wb_latency", wb_q.size(), 0);
        blk_en = 1'b0;
        @(posedge clk);
        #1;

        // Reset during beat 1 of a load.
        set_entry(v_clr);
        guard = 0;
        @(negedge clk);
        while (!(mem_req === 1'b1 && mem_addr == 32'h101) && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        check("clr_reach_beat1", guard < 50, 1);
        clr = 1'b1;
        drive_bubble();
        @(posedge clk);
        #1;
        clr = 1'b0;
        @(negedge clk);
        check("clr_mem_req", mem_req, 0);
        check("clr_stall", stall, 0);
        check("clr_wb_valid", wb_valid, 0);
        check("clr_wb_we", wb_we, 0);
        check("clr_wb_data", wb_data, 0);
        check("clr_wb_rd", wb_rd, 0);
        check("clr_mem_err", mem_err, 0);
        check("clr_bus_pending", bus_q.size(), 0);
        @(posedge clk);
        #1;
        run_vec(v_reload, "reload");

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("end_wb_queue", wb_q.size(), 0);
        check("end_bus_queue", bus_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
